// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one pipelined fp32 adder among NREQ requesters
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of all in-flight operations
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         packed operands, requester i at [32i+31:32i]
//   add_a/add_b         registered operands driven to the external adder
//   add_s               sum returned by the external adder (ADD_LAT cycles)
//   res_valid/res_id    one-cycle result strobe with originating requester id
//   res_sum             registered sum
//   inflight            ops issued and not yet returned
//
// Build option: define FP_ADD_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer).

module fp_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_s,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [31:0]          res_sum,
    output logic [3:0]           inflight
);

    // One tag stage per adder cycle plus the operand register stage.
    localparam int NST = ADD_LAT + 1;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic [31:0]     win_a;
    logic [31:0]     win_b;
    logic            accept;

    logic [NST-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [NST];

`ifndef FP_ADD_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  ptr;
`endif

    always_comb begin
        logic found;
        grant  = '0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
            idx = k;
`else
            // Scan upward from the pointer with an explicit wrap so that
            // non-power-of-two NREQ never indexes past the last requester.
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
`endif
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                win_id      = IDW'(idx);
                win_a       = req_a[32*idx +: 32];
                win_b       = req_b[32*idx +: 32];
            end
        end
        // No grant during reset or flush: nothing may be accepted then.
        if (!rst_n || flush) begin
            grant = '0;
        end
        accept = |grant;
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            inflight  <= '0;
            tag_v     <= '0;
            for (int i = 0; i < NST; i++) begin
                tag_id[i] <= '0;
            end
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            // Operands only move on an accept so the adder input is stable otherwise.
            if (accept) begin
                add_a <= win_a;
                add_b <= win_b;
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
                if (win_id == IDW'(NREQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= win_id + IDW'(1);
                end
`endif
            end

            tag_v[0]  <= accept;
            tag_id[0] <= win_id;
            for (int i = 1; i < NST; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            res_id <= tag_id[NST-1];
            if (tag_v[NST-1]) begin
                res_sum <= add_s;
            end

            if (flush) begin
                tag_v     <= '0;
                res_valid <= 1'b0;
                inflight  <= '0;
            end else begin
                res_valid <= tag_v[NST-1];
                // Count only changes when exactly one of issue/return happens.
                if (accept && !tag_v[NST-1]) begin
                    inflight <= inflight + 4'd1;
                end else if (!accept && tag_v[NST-1]) begin
                    inflight <= inflight - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - randomized self-checking bench for fp_add_arbiter with fp32 adder model

module tb_fp_add_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic [31:0]         add_s;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [31:0]         res_sum;
    logic [3:0]          inflight;

    fp_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fp32 <-> real conversion for normal numbers and zero.
    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] rnd_op();
        return r2s(real'($urandom_range(1, 4000)));
    endfunction

    // External adder model: LAT register stages, combinational sum at the end.
    logic [31:0] pa [LAT];
    logic [31:0] pb [LAT];
    always @(posedge clk) begin
        pa[0] <= add_a;
        pb[0] <= add_b;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    always_comb add_s = fadd(pa[LAT-1], pb[LAT-1]);

    // Reference model: queue of expected results, each with the cycle it appears.
    typedef struct {
        int             due;
        logic [IDW-1:0] id;
        logic [31:0]    sum;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr      = 0;
    logic [31:0] opa [NREQ];
    logic [31:0] opb [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
            int i = k;
`else
            int i = (ptr + k) % NREQ;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check grant, advance model, check registered outputs.
    task automatic step(input logic [NREQ-1:0] v, input logic fl);
        int w;
        logic [NREQ-1:0] eg;
        exp_t e;
        req_valid = v;
        flush     = fl;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
        end
        #1;
        w  = fl ? -1 : pick(v);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (fl) q.delete();
        if (w >= 0) begin
            e.due = cyc + 1 + LAT + 1;
            e.id  = IDW'(w);
            e.sum = fadd(opa[w], opb[w]);
            q.push_back(e);
            ptr = (w + 1) % NREQ;
        end
        @(posedge clk);
        cyc++;
        if (w >= 0) begin
            opa[w] = rnd_op();
            opb[w] = rnd_op();
        end
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_sum", res_sum, q[0].sum);
            void'(q.pop_front());
        end else begin
            chk("res_valid", 32'(res_valid), 32'd0);
        end
        chk("inflight", 32'(inflight), 32'(q.size()));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        req_valid = '1;
        flush     = 1'b0;
        #1;
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_res_sum", res_sum, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        q.delete();
        ptr = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("rst_hold_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = rnd_op();
            opb[i] = rnd_op();
        end
        @(negedge clk);
        do_reset();

        // Single op on requester 1: 1.0 + 2.0 = 3.0
        opa[1] = 32'h3F800000;
        opb[1] = 32'h40000000;
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("single_sum", res_sum, 32'h40400000);
        chk("single_id", 32'(res_id), 32'd1);
        repeat (2) step(4'b0000, 1'b0);

        // Contention from reset: all requesters valid
        @(negedge clk);
        do_reset();
        repeat (12) step(4'b1111, 1'b0);
        repeat (4) step(4'b0000, 1'b0);

        // Wrap with sparse requests: move pointer to 3, then only 0 and 2 valid
        do_reset();
        step(4'b0100, 1'b0);
        repeat (3) step(4'b0101, 1'b0);
        repeat (4) step(4'b0000, 1'b0);

        // Flush one cycle after three back-to-back accepts
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1111, 1'b1);
        chk("flush_inflight", 32'(inflight), 32'd0);
        repeat (5) step(4'b0000, 1'b0);

        // Async reset mid-stream with two ops in flight
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        chk("pre_rst_inflight", 32'(inflight), 32'd2);
        do_reset();
        repeat (5) step(4'b0000, 1'b0);

        // Randomized traffic with occasional flush
        for (int n = 0; n < 1500; n++) begin
            step(NREQ'($urandom_range(0, (1 << NREQ) - 1)), ($urandom_range(0, 19) == 0));
        end
        repeat (LAT + 3) step(4'b0000, 1'b0);
        chk("drain_inflight", 32'(inflight), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
